// File: rtl/lcd_seq_pkg.sv
// Shared encodings for the LCD command sequencer: ROM entry layout,
// display-bus register addresses and the sequencer state enum.
package lcd_seq_pkg;

  // ROM entry = {type[1:0], payload[7:0]}
  localparam int ENTRY_W = 10;
  localparam int ROM_AW  = 3;

  // Display-bus register addresses used by the init sequence
  localparam int unsigned ADDR_DATA = 2;
  localparam int unsigned ADDR_CMD  = 3;

  typedef enum logic [1:0] {
    ENT_CMD   = 2'd0,
    ENT_DATA  = 2'd1,
    ENT_DELAY = 2'd2,
    ENT_END   = 2'd3
  } entry_type_e;

  typedef enum logic [2:0] {
    ST_INIT_FETCH,
    ST_INIT_WAIT,
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_GAP
  } state_e;

  function automatic logic [ENTRY_W-1:0] make_entry(input entry_type_e t, input logic [7:0] p);
    return {t, p};
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Power-on init sequence for the display, one entry per pointer value.
// Pointers past the last programmed entry read back as END.
module lcd_init_rom
  import lcd_seq_pkg::*;
(
  input  logic [ROM_AW-1:0]  ptr,
  output logic [ENTRY_W-1:0] entry
);

  // Combinational lookup of the default init sequence
  always_comb begin
    entry = make_entry(ENT_END, 8'h00);
    case (ptr)
      3'd0: entry = make_entry(ENT_CMD,   8'h01);
      3'd1: entry = make_entry(ENT_DELAY, 8'd5);
      3'd2: entry = make_entry(ENT_CMD,   8'h11);
      3'd3: entry = make_entry(ENT_DELAY, 8'd120);
      3'd4: entry = make_entry(ENT_CMD,   8'h3A);
      3'd5: entry = make_entry(ENT_DATA,  8'h55);
      3'd6: entry = make_entry(ENT_CMD,   8'h29);
      default: entry = make_entry(ENT_END, 8'h00);
    endcase
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Upstream feeder for the LCD write stage: plays the ROM init sequence after
// reset, then drains host writes from a small FIFO. Every write is emitted as
// SETUP (addr/data stable) -> STROBE (wrEn high) -> GAP (wrEn low).
module lcd_cmd_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int WR_CYC     = 2,
  parameter int GAP_CYC    = 4,
  parameter int DELAY_UNIT = 1000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_full,
  output logic [ADDR_W-1:0] commAddr,
  output logic [DATA_W-1:0] commData,
  output logic              wrEn,
  output logic              busy,
  output logic              init_done,
  output logic              ovf
);

  // Wide enough for 255 * DELAY_UNIT without wrapping
  localparam int CNT_W   = 8 + $clog2(DELAY_UNIT);
  localparam int FIFO_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e              state;
  logic [ROM_AW-1:0]   rom_ptr;
  logic [ENTRY_W-1:0]  rom_entry;
  entry_type_e         rom_type;
  logic [7:0]          rom_payload;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    delay_load;

  logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr;
  logic [FIFO_AW-1:0]  rd_ptr;
  logic [COUNT_W-1:0]  fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;

  lcd_init_rom u_rom (
    .ptr   (rom_ptr),
    .entry (rom_entry)
  );

  assign rom_type    = entry_type_e'(rom_entry[ENTRY_W-1 -: 2]);
  assign rom_payload = rom_entry[7:0];
  assign delay_load  = CNT_W'(rom_payload) * CNT_W'(DELAY_UNIT) - CNT_W'(1);

  // Full is judged before any same-cycle pop, so a push while full is lost
  assign fifo_full  = (fifo_count == COUNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign push       = host_wr && !fifo_full;
  assign pop        = (state == ST_IDLE) && init_done && !fifo_empty;

  assign host_full  = fifo_full;
  assign busy       = (state != ST_IDLE) || !fifo_empty;

  // FIFO storage; contents need no reset because the count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= host_addr;
      fifo_data[wr_ptr] <= host_data;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ovf        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      if (host_wr && fifo_full) ovf <= 1'b1;
    end
  end

  // Sequencer FSM with registered display-bus outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_INIT_FETCH;
      rom_ptr   <= '0;
      cnt       <= '0;
      commAddr  <= '0;
      commData  <= '0;
      wrEn      <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT_FETCH: begin
          case (rom_type)
            ENT_CMD, ENT_DATA: begin
              commAddr <= (rom_type == ENT_CMD) ? ADDR_W'(ADDR_CMD) : ADDR_W'(ADDR_DATA);
              commData <= DATA_W'(rom_payload);
              state    <= ST_SETUP;
            end
            ENT_DELAY: begin
              rom_ptr <= rom_ptr + 1'b1;
              if (rom_payload != 8'd0) begin
                cnt   <= delay_load;
                state <= ST_INIT_WAIT;
              end
            end
            default: begin
              init_done <= 1'b1;
              state     <= ST_IDLE;
            end
          endcase
        end
        ST_INIT_WAIT: begin
          if (cnt == '0) state <= ST_INIT_FETCH;
          else           cnt   <= cnt - 1'b1;
        end
        ST_IDLE: begin
          if (pop) begin
            commAddr <= fifo_addr[rd_ptr];
            commData <= fifo_data[rd_ptr];
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          cnt   <= CNT_W'(WR_CYC - 1);
          wrEn  <= 1'b1;
          state <= ST_STROBE;
        end
        ST_STROBE: begin
          if (cnt == '0) begin
            wrEn  <= 1'b0;
            cnt   <= CNT_W'(GAP_CYC - 1);
            state <= ST_GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            if (init_done) begin
              state <= ST_IDLE;
            end else begin
              rom_ptr <= rom_ptr + 1'b1;
              state   <= ST_INIT_FETCH;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_INIT_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Self-checking bench for lcd_cmd_sequencer. Expected transactions and their
// spacing come from an abstract model: the init list is walked as data, each
// write costs a fixed issue period, each delay adds its wait plus one fetch,
// and the host FIFO is modelled as a bounded queue.
module tb_lcd_cmd_sequencer;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 3;
  localparam int WR_CYC     = 2;
  localparam int GAP_CYC    = 4;
  localparam int DELAY_UNIT = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int PERIOD     = 2 + WR_CYC + GAP_CYC;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                gap;
  } txn_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } obs_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              host_wr = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_data = '0;
  logic              host_full;
  logic [ADDR_W-1:0] commAddr;
  logic [DATA_W-1:0] commData;
  logic              wrEn;
  logic              busy;
  logic              init_done;
  logic              ovf;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cyc = -1;
  int   hi_len = 0;
  int   n_init = 0;
  logic wr_prev = 1'b0;
  logic done_prev = 1'b0;
  logic model_ovf = 1'b0;
  obs_t obs_q[$];
  int   len_q[$];
  txn_t exp_q[$];

  // Default init sequence as the display datasheet lists it: type, payload
  int rom_type[8] = '{0, 2, 0, 2, 0, 1, 0, 3};
  int rom_pay[8]  = '{'h01, 5, 'h11, 120, 'h3A, 'h55, 'h29, 0};

  lcd_cmd_sequencer #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .WR_CYC     (WR_CYC),
    .GAP_CYC    (GAP_CYC),
    .DELAY_UNIT (DELAY_UNIT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .host_wr   (host_wr),
    .host_addr (host_addr),
    .host_data (host_data),
    .host_full (host_full),
    .commAddr  (commAddr),
    .commData  (commData),
    .wrEn      (wrEn),
    .busy      (busy),
    .init_done (init_done),
    .ovf       (ovf)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Free-running cycle counter used to timestamp strobes
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: records addr/data at each wrEn rise, high length at each fall
  always @(negedge clk) begin
    if (wrEn === 1'b1 && wr_prev !== 1'b1) begin
      obs_q.push_back('{addr: commAddr, data: commData, cyc: cyc});
      hi_len = 1;
    end else if (wrEn === 1'b1) begin
      hi_len++;
    end else if (wr_prev === 1'b1) begin
      len_q.push_back(hi_len);
    end
    if (init_done === 1'b1 && done_prev !== 1'b1) done_cyc = cyc;
    wr_prev   = wrEn;
    done_prev = init_done;
  end

  // Last-resort guard so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    host_wr   = 1'b1;
    host_addr = a;
    host_data = d;
    @(negedge clk);
    host_wr   = 1'b0;
  endtask

  task automatic waitStrobes(input int n, input int budget, input string tag);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, obs_q.size(), n);
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, 32'(busy), 0);
  endtask

  // Walk the init list: a write costs PERIOD, a delay adds one fetch plus its wait
  task automatic buildInitModel();
    int pending = 0;
    exp_q.delete();
    n_init = 0;
    for (int i = 0; i < 8; i++) begin
      if (rom_type[i] <= 1) begin
        exp_q.push_back('{addr: ADDR_W'((rom_type[i] == 0) ? 3 : 2),
                          data: DATA_W'(rom_pay[i]),
                          gap:  (n_init == 0) ? -1 : PERIOD + pending});
        pending = 0;
        n_init++;
      end else if (rom_type[i] == 2) begin
        pending += 1 + rom_pay[i] * DELAY_UNIT;
      end else begin
        break;
      end
    end
  endtask

  task automatic checkStrobes(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) begin
        checkOutput($sformatf("%s[%0d].addr", tag, i), 32'(obs_q[i].addr), 32'(exp_q[i].addr));
        checkOutput($sformatf("%s[%0d].data", tag, i), 32'(obs_q[i].data), 32'(exp_q[i].data));
        if (i > 0 && exp_q[i].gap >= 0)
          checkOutput($sformatf("%s[%0d].gap", tag, i), obs_q[i].cyc - obs_q[i-1].cyc, exp_q[i].gap);
      end
      if (i < len_q.size())
        checkOutput($sformatf("%s[%0d].wr_len", tag, i), len_q[i], WR_CYC);
    end
  endtask

  // Lead write followed one clock later by n back-to-back writes; the lead
  // transaction keeps the sequencer occupied so nothing leaves the FIFO
  // during the burst
  task automatic runBurst(input int n, input string tag);
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int occ = 0;
    waitIdle(400, {tag, "_idle_before"});
    obs_q.delete();
    len_q.delete();
    exp_q.delete();
    a = ADDR_W'($urandom_range(0, 7));
    d = DATA_W'($urandom_range(0, 255));
    applyStimulus(a, d);
    exp_q.push_back('{addr: a, data: d, gap: -1});
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      a = ADDR_W'($urandom_range(0, 7));
      d = DATA_W'($urandom_range(0, 255));
      applyStimulus(a, d);
      if (occ < FIFO_DEPTH) begin
        occ++;
        exp_q.push_back('{addr: a, data: d, gap: PERIOD});
      end else begin
        model_ovf = 1'b1;
      end
      checkOutput($sformatf("%s_full_%0d", tag, k), 32'(host_full), 32'(occ == FIFO_DEPTH));
      checkOutput($sformatf("%s_ovf_%0d", tag, k), 32'(ovf), 32'(model_ovf));
    end
    waitStrobes(exp_q.size(), 200, {tag, "_strobes"});
    repeat (PERIOD) @(negedge clk);
    checkStrobes(tag);
    waitIdle(200, {tag, "_idle_after"});
    checkOutput({tag, "_count"}, obs_q.size(), exp_q.size());
    checkOutput({tag, "_ovf_sticky"}, 32'(ovf), 32'(model_ovf));
  endtask

  // Directed sequence of scenarios, each using randomized host traffic
  initial begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int k;

    $display("[TB] start");
    repeat (2) @(negedge clk);
    checkOutput("rst_wrEn",      32'(wrEn),      0);
    checkOutput("rst_commAddr",  32'(commAddr),  0);
    checkOutput("rst_commData",  32'(commData),  0);
    checkOutput("rst_busy",      32'(busy),      1);
    checkOutput("rst_init_done", 32'(init_done), 0);
    checkOutput("rst_ovf",       32'(ovf),       0);
    checkOutput("rst_host_full", 32'(host_full), 0);

    // Init replay with two host writes queued while init is still running
    buildInitModel();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      a = ADDR_W'($urandom_range(0, 7));
      d = DATA_W'($urandom_range(0, 255));
      applyStimulus(a, d);
      exp_q.push_back('{addr: a, data: d, gap: (j == 0) ? PERIOD + 1 : PERIOD});
    end
    checkOutput("init_not_done_yet", 32'(init_done), 0);
    waitStrobes(exp_q.size(), 3000, "init_strobes");
    repeat (PERIOD) @(negedge clk);
    checkStrobes("init");
    if (obs_q.size() >= n_init)
      checkOutput("init_done_rise", done_cyc, obs_q[n_init-1].cyc + WR_CYC + GAP_CYC + 1);

    // Single post-init write: k-th negedge after the sampling edge shows the
    // state entered on edge E0+k (SETUP at k=1, STROBE for WR_CYC clocks, GAP)
    waitIdle(200, "single_idle_before");
    applyStimulus(3'd2, 8'hA5);
    for (int j = 1; j <= PERIOD; j++) begin
      @(negedge clk);
      checkOutput($sformatf("single_wrEn_%0d", j), 32'(wrEn), 32'(j >= 2 && j <= 1 + WR_CYC));
      checkOutput($sformatf("single_data_%0d", j), 32'(commData), 32'hA5);
      checkOutput($sformatf("single_addr_%0d", j), 32'(commAddr), 32'd2);
      checkOutput($sformatf("single_busy_%0d", j), 32'(busy), 32'(j < PERIOD));
    end

    // Bursts that exactly fill and then overflow the FIFO
    runBurst(4, "burst4");
    runBurst(5, "burst5");

    // Reset in the middle of a strobe with two writes still queued
    waitIdle(200, "rstmid_idle_before");
    for (int j = 0; j < 3; j++)
      applyStimulus(ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom_range(0, 255)));
    k = 0;
    while (wrEn !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("rstmid_in_strobe", 32'(wrEn), 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("rstmid_wrEn",      32'(wrEn),      0);
    checkOutput("rstmid_host_full", 32'(host_full), 0);
    checkOutput("rstmid_busy",      32'(busy),      1);
    checkOutput("rstmid_init_done", 32'(init_done), 0);
    checkOutput("rstmid_ovf",       32'(ovf),       0);
    checkOutput("rstmid_commAddr",  32'(commAddr),  0);
    checkOutput("rstmid_commData",  32'(commData),  0);
    repeat (2) @(negedge clk);
    obs_q.delete();
    len_q.delete();
    done_cyc = -1;
    model_ovf = 1'b0;
    buildInitModel();
    rst = 1'b1;
    waitStrobes(n_init, 3000, "replay_strobes");
    k = 0;
    while (init_done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (3 * PERIOD) @(negedge clk);
    checkStrobes("replay");
    checkOutput("replay_count", obs_q.size(), n_init);
    checkOutput("replay_busy", 32'(busy), 0);
    checkOutput("replay_init_done", 32'(init_done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
